// File: rtl/imem_responder_if.sv
// Request/response bundle between an instruction fetch buffer (master)
// and a memory responder (slave).
interface imem_responder_if;
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_fence, mem_spec, mem_instr, mem_mode,
               mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_error, mem_ready
    );

    modport slave (
        input  mem_valid, mem_fence, mem_spec, mem_instr, mem_mode,
               mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_error, mem_ready
    );
endinterface

// File: rtl/imem_responder.sv
// Memory-side responder for instruction fetch: word-addressed SRAM with
// configurable wait states, byte-strobed writes and speculative cancellation.
module imem_responder #(
    parameter int unsigned mem_depth   = 10,
    parameter logic [31:0] mem_base    = 32'h0,
    parameter int unsigned wait_cycles = 1
) (
    input logic              clock,
    input logic              reset,
    imem_responder_if.slave  imem
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int unsigned WORDS     = 2 ** mem_depth;
    localparam logic [32:0] MEM_LIMIT = {1'b0, mem_base} + (33'd4 << mem_depth);
    localparam logic [3:0]  WAIT_INIT = 4'(wait_cycles);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        fence_q, fence_d;
    logic        instr_q, instr_d;

    logic [31:0] mem_q [WORDS];

    logic                 accept;
    logic                 in_resp;
    logic                 access_err;
    logic                 do_write;
    logic                 do_read;
    logic [31:0]          offset;
    logic [mem_depth-1:0] word_idx;
    logic                 unused_bits;

    assign offset      = addr_q - mem_base;
    assign word_idx    = offset[mem_depth+1:2];
    assign unused_bits = ^{imem.mem_mode, offset};

    // 33-bit compares so a base near the top of the address space cannot wrap.
    assign access_err = ({1'b0, addr_q} < {1'b0, mem_base})
                     || ({1'b0, addr_q} >= MEM_LIMIT)
                     || (addr_q[1:0] != 2'b00)
                     || (instr_q && (wstrb_q != '0));

    assign in_resp  = (state_q == RESP) && !imem.mem_spec;
    assign accept   = ((state_q == IDLE) || (state_q == RESP))
                   && imem.mem_valid && !imem.mem_spec;
    assign do_write = in_resp && !access_err && !fence_q && (wstrb_q != '0);
    assign do_read  = in_resp && !access_err && !fence_q && (wstrb_q == '0);

    always_comb begin
        imem.mem_ready = in_resp;
        imem.mem_error = in_resp && access_err;
        imem.mem_rdata = do_read ? mem_q[word_idx] : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        fence_d = fence_q;
        instr_d = instr_q;

        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A new request may ride on the RESP cycle of the previous one.
        if (accept) begin
            addr_d  = imem.mem_addr;
            wdata_d = imem.mem_wdata;
            wstrb_d = imem.mem_wstrb;
            fence_d = imem.mem_fence;
            instr_d = imem.mem_instr;
            cnt_d   = WAIT_INIT;
            state_d = (wait_cycles == 0) ? RESP : WAIT;
        end

        if (imem.mem_spec) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            fence_q <= 1'b0;
            instr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            fence_q <= fence_d;
            instr_q <= instr_d;
        end
    end

    // Array contents survive reset; only the in-flight write is suppressed.
    always_ff @(posedge clock) begin
        if (!reset && do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench driving three responders (0, 1 and 3 wait states)
// through a shared request bus gated by a selector.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 1;
    logic        req_valid = 1'b0;
    logic        req_spec  = 1'b0;
    logic        req_fence = 1'b0;
    logic        req_instr = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int unsigned due;
    } exp_t;
    exp_t q[$];

    imem_responder_if if0 ();
    imem_responder_if if1 ();
    imem_responder_if if3 ();

    assign if0.mem_valid = req_valid && (sel == 0);
    assign if1.mem_valid = req_valid && (sel == 1);
    assign if3.mem_valid = req_valid && (sel == 3);
    assign if0.mem_spec  = req_spec && (sel == 0);
    assign if1.mem_spec  = req_spec && (sel == 1);
    assign if3.mem_spec  = req_spec && (sel == 3);
    assign {if0.mem_fence, if1.mem_fence, if3.mem_fence} = {3{req_fence}};
    assign {if0.mem_instr, if1.mem_instr, if3.mem_instr} = {3{req_instr}};
    assign if0.mem_mode  = 2'b11;
    assign if1.mem_mode  = 2'b11;
    assign if3.mem_mode  = 2'b00;
    assign if0.mem_addr  = req_addr;
    assign if1.mem_addr  = req_addr;
    assign if3.mem_addr  = req_addr;
    assign if0.mem_wdata = req_wdata;
    assign if1.mem_wdata = req_wdata;
    assign if3.mem_wdata = req_wdata;
    assign if0.mem_wstrb = req_wstrb;
    assign if1.mem_wstrb = req_wstrb;
    assign if3.mem_wstrb = req_wstrb;

    imem_responder #(.mem_depth(10), .mem_base(32'h0), .wait_cycles(0))
        u_w0 (.clock(clk), .reset(rst), .imem(if0));
    imem_responder #(.mem_depth(10), .mem_base(32'h0), .wait_cycles(1))
        u_w1 (.clock(clk), .reset(rst), .imem(if1));
    imem_responder #(.mem_depth(10), .mem_base(32'h0), .wait_cycles(3))
        u_w3 (.clock(clk), .reset(rst), .imem(if3));

    logic        o_ready;
    logic        o_error;
    logic [31:0] o_rdata;
    assign o_ready = (sel == 0) ? if0.mem_ready : (sel == 1) ? if1.mem_ready : if3.mem_ready;
    assign o_error = (sel == 0) ? if0.mem_error : (sel == 1) ? if1.mem_error : if3.mem_error;
    assign o_rdata = (sel == 0) ? if0.mem_rdata : (sel == 1) ? if1.mem_rdata : if3.mem_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned wsel();
        return (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
    endfunction

    task automatic push(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        e.due = cyc + 1 + wsel();
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && q.size() != 0; c++) step(1);
        n_vec++;
        assert (q.size() == 0) else begin
            n_miss++;
            $error("FAIL drain_timeout pending=%0d want 0", q.size());
        end
        q.delete();
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic instr, input logic fence,
                       input logic [31:0] exp_rd, input logic exp_err);
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        req_instr = instr;
        req_fence = fence;
        req_valid = 1'b1;
        push(exp_rd, exp_err);
        step(1);
        req_valid = 1'b0;
        req_wstrb = '0;
        req_instr = 1'b0;
        req_fence = 1'b0;
        drain();
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (o_ready) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_miss++;
                    $error("FAIL unexpected_ready cyc=%0d got ready=1 want 0", cyc);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_vec += 3;
                    assert (o_rdata === e.rd) else begin
                        n_miss++;
                        $error("FAIL rdata got %h want %h", o_rdata, e.rd);
                    end
                    assert (o_error === e.err) else begin
                        n_miss++;
                        $error("FAIL error got %b want %b", o_error, e.err);
                    end
                    assert (cyc === e.due) else begin
                        n_miss++;
                        $error("FAIL latency got cyc %0d want cyc %0d", cyc, e.due);
                    end
                end
            end else begin
                n_vec++;
                assert ({o_error, o_rdata} === 33'd0) else begin
                    n_miss++;
                    $error("FAIL idle_outputs got err=%b rdata=%h want 0/0", o_error, o_rdata);
                end
            end
        end
    end

    logic [31:0] stream_val [3];
    int          idx;

    initial begin
        step(2);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1);
            n_vec += 3;
            assert ({if0.mem_ready, if0.mem_error, if0.mem_rdata} === 34'd0) else begin
                n_miss++;
                $error("FAIL reset_w0 got %b/%b/%h want 0", if0.mem_ready, if0.mem_error, if0.mem_rdata);
            end
            assert ({if1.mem_ready, if1.mem_error, if1.mem_rdata} === 34'd0) else begin
                n_miss++;
                $error("FAIL reset_w1 got %b/%b/%h want 0", if1.mem_ready, if1.mem_error, if1.mem_rdata);
            end
            assert ({if3.mem_ready, if3.mem_error, if3.mem_rdata} === 34'd0) else begin
                n_miss++;
                $error("FAIL reset_w3 got %b/%b/%h want 0", if3.mem_ready, if3.mem_error, if3.mem_rdata);
            end
        end
        mon_en = 1'b1;

        // One wait state: full write, byte write, reads, error and fence cases.
        sel = 1;
        req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        req(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
        req(32'h10, 32'h0000AA00, 4'b0010, 1'b0, 1'b0, 32'h0, 1'b0);
        req(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADAAEF, 1'b0);
        req(32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        req(32'h2, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        req(32'h10, 32'hFFFFFFFF, 4'h1, 1'b1, 1'b0, 32'h0, 1'b1);
        req(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADAAEF, 1'b0);
        req(32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        req(32'hFFC, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        req(32'hFFC, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0);

        // Zero wait states: preload then stream three reads back to back.
        sel = 0;
        stream_val[0] = 32'h11111111;
        stream_val[1] = 32'h22222222;
        stream_val[2] = 32'h33333333;
        for (int i = 0; i < 3; i++)
            req(32'(i * 4), stream_val[i], 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        idx = 0;
        req_addr  = 32'h0;
        req_wstrb = 4'h0;
        req_valid = 1'b1;
        push(stream_val[0], 1'b0);
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1);
            if (o_ready) begin
                idx++;
                if (idx < 3) begin
                    req_addr = 32'(idx * 4);
                    push(stream_val[idx], 1'b0);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        drain();

        // Three wait states: cancellation mid-wait and same-cycle spec rejection.
        sel = 3;
        req(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        req_addr  = 32'h0;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        step(1);
        req_spec = 1'b1;
        step(1);
        req_spec = 1'b0;
        step(6);
        req_valid = 1'b1;
        req_spec  = 1'b1;
        step(1);
        req_valid = 1'b0;
        req_spec  = 1'b0;
        step(6);
        req(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT discards the pending write.
        sel = 1;
        req(32'h20, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        req_addr  = 32'h20;
        req_wdata = 32'hFFFFFFFF;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        req_wstrb = 4'h0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        req(32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 32'h12345678, 1'b0);
        req(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADAAEF, 1'b0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
